// File: rtl/uart_transmitter_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_transmitter_pkg;

    // Transmit frame sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } uart_tx_state_e;

    // Stop-bit selection encoding, identical to the register block's field
    localparam logic [1:0] STOP_ONE = 2'b01;
    localparam logic [1:0] STOP_TWO = 2'b10;

    // Number of stop-bit periods for a selection; anything but STOP_TWO is one
    function automatic logic [1:0] stop_periods(input logic [1:0] sel);
        return (sel == STOP_TWO) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_gen.sv
// Bit-period timer: counts 0..eff_div-1 and flags the last cycle of each bit.
// Latency: tick is combinational from the registered count; restart clears it next cycle.
// Backpressure: none; counts whenever enabled, held at zero otherwise.
module uart_baud_gen #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [width-1:0] eff_div,
    output logic             tick
);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    // Tick on the final cycle of a bit period; next count wraps, restarts or holds at zero
    always_comb begin
        cnt_d = cnt_q;
        tick  = enable && (cnt_q == (eff_div - width'(1)));
        if (restart || !enable) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + width'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Serial TX engine: sends one 8N1/8N2 frame, LSB first, per loaded byte.
// Latency: line falls 1 cycle after load&&enable is sampled; pulse (1+DATA_BITS+nstop)*eff_div cycles later.
// Backpressure: busy high for the whole frame; load is ignored until the FSM is back in IDLE.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int width     = 32,
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             load_signal,
    input  logic             tx_signal,
    input  logic [width-1:0] baud_div,
    input  logic [1:0]       stop_bit,
    output logic             tx_serial,
    output logic             busy,
    output logic             data_transmitted
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_tx_state_e         state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [1:0]             stop_cnt_q, stop_cnt_d;
    logic [1:0]             nstop_q, nstop_d;
    logic [width-1:0]       eff_div_q, eff_div_d;
    logic                   tx_serial_q, tx_serial_d;
    logic                   data_transmitted_q, data_transmitted_d;

    logic                   baud_en;
    logic                   baud_restart;
    logic                   tick;

    // The timer runs only while a bit is on the line; DONE and IDLE keep it cleared
    assign baud_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_baud_gen #(
        .width (width)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (baud_en),
        .restart (baud_restart),
        .eff_div (eff_div_q),
        .tick    (tick)
    );

    // Frame sequencer: next state, datapath updates and next registered outputs
    always_comb begin
        state_d            = state_q;
        shift_d            = shift_q;
        bit_idx_d          = bit_idx_q;
        stop_cnt_d         = stop_cnt_q;
        nstop_d            = nstop_q;
        eff_div_d          = eff_div_q;
        tx_serial_d        = tx_serial_q;
        data_transmitted_d = 1'b0;
        baud_restart       = 1'b0;

        case (state_q)
            IDLE: begin
                tx_serial_d = 1'b1;
                // Everything that shapes the frame is captured here so later
                // register writes cannot disturb a frame in flight
                if (load_signal && tx_signal) begin
                    state_d      = START;
                    shift_d      = DATA_BITS'(tx_data);
                    eff_div_d    = (baud_div == '0) ? width'(1) : baud_div;
                    nstop_d      = stop_periods(stop_bit);
                    bit_idx_d    = '0;
                    stop_cnt_d   = '0;
                    tx_serial_d  = 1'b0;
                    baud_restart = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    state_d     = DATA;
                    tx_serial_d = shift_q[0];
                    bit_idx_d   = '0;
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d     = STOP;
                        tx_serial_d = 1'b1;
                        stop_cnt_d  = '0;
                    end else begin
                        // shift_q[1] becomes the new LSB on the line
                        shift_d     = shift_q >> 1;
                        bit_idx_d   = bit_idx_q + IDX_W'(1);
                        tx_serial_d = shift_q[1];
                    end
                end
            end

            STOP: begin
                tx_serial_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == (nstop_q - 2'd1)) begin
                        state_d            = DONE;
                        data_transmitted_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
            end

            DONE: begin
                // Guard cycle: the register block clears its full flag off the
                // pulse before IDLE looks at load_signal again
                tx_serial_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                tx_serial_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any frame with the line high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            shift_q            <= '0;
            bit_idx_q          <= '0;
            stop_cnt_q         <= '0;
            nstop_q            <= 2'd1;
            eff_div_q          <= width'(1);
            tx_serial_q        <= 1'b1;
            data_transmitted_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            shift_q            <= shift_d;
            bit_idx_q          <= bit_idx_d;
            stop_cnt_q         <= stop_cnt_d;
            nstop_q            <= nstop_d;
            eff_div_q          <= eff_div_d;
            tx_serial_q        <= tx_serial_d;
            data_transmitted_q <= data_transmitted_d;
        end
    end

    assign tx_serial        = tx_serial_q;
    assign data_transmitted = data_transmitted_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboarded bench for uart_transmitter: stimulus queues expected frames, a line monitor checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tx_data;
    logic        load_signal;
    logic        tx_signal;
    logic [31:0] baud_div;
    logic [1:0]  stop_bit;
    logic        tx_serial;
    logic        busy;
    logic        data_transmitted;

    always #5 clk = ~clk;

    uart_transmitter #(
        .width     (32),
        .DATA_BITS (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .tx_data          (tx_data),
        .load_signal      (load_signal),
        .tx_signal        (tx_signal),
        .baud_div         (baud_div),
        .stop_bit         (stop_bit),
        .tx_serial        (tx_serial),
        .busy             (busy),
        .data_transmitted (data_transmitted)
    );

    // Expected frame: data byte, effective bit period, stop periods,
    // whether a reset should cut it short, and required distance from the previous pulse
    typedef struct {
        logic [7:0] data;
        int         div;
        int         nstop;
        bit         abort;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks        = 0;
    int   errors        = 0;
    int   cyc           = 0;
    int   last_pulse    = -1000;
    int   frames_seen   = 0;
    int   frames_pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input int div, input int ns,
                                input bit ab, input int gap);
        exp_t e;
        e.data  = d;
        e.div   = div;
        e.nstop = ns;
        e.abort = ab;
        e.gap   = gap;
        return e;
    endfunction

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        if (!e.abort) frames_pushed++;
    endtask

    task automatic wait_pulse(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (data_transmitted === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(seen, name, seen, 1);
    endtask

    // Line monitor: on every falling edge of an idle line, pop the expected
    // frame and check it cycle by cycle, then the done pulse and guard cycle
    initial begin : monitor
        exp_t       e;
        int         total;
        int         bad_lvl;
        int         bad_ctl;
        int         b;
        logic       lvl;
        logic [7:0] rx;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx_serial === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", 1, 0);
                    for (int i = 0; i < 2000; i++) begin
                        @(negedge clk);
                        if (tx_serial === 1'b1) break;
                    end
                end else begin
                    e = exp_q.pop_front();
                    if (e.gap != 0)
                        check((cyc - last_pulse) == e.gap, "frame_gap", cyc - last_pulse, e.gap);
                    total   = (9 + e.nstop) * e.div;
                    bad_lvl = 0;
                    bad_ctl = 0;
                    rx      = 8'h00;
                    aborted = 1'b0;
                    for (int k = 0; k < total; k++) begin
                        if (k > 0) @(negedge clk);
                        if (reset === 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        b   = k / e.div;
                        lvl = (b == 0) ? 1'b0 : ((b <= 8) ? e.data[b-1] : 1'b1);
                        if (tx_serial !== lvl) bad_lvl++;
                        if (busy !== 1'b1 || data_transmitted !== 1'b0) bad_ctl++;
                        if (b >= 1 && b <= 8 && (k % e.div) == (e.div / 2))
                            rx[b-1] = tx_serial;
                    end
                    check(aborted == e.abort, "abort_match", aborted, e.abort);
                    if (!aborted) begin
                        check(bad_lvl == 0, "frame_bits_bad_cycles", bad_lvl, 0);
                        check(rx == e.data, "frame_data", rx, e.data);
                        check(bad_ctl == 0, "busy_in_frame_bad_cycles", bad_ctl, 0);
                        @(negedge clk);
                        check(data_transmitted === 1'b1 && tx_serial === 1'b1 && busy === 1'b1,
                              "pulse_at_end", data_transmitted, 1);
                        last_pulse = cyc;
                        frames_seen++;
                        @(negedge clk);
                        check(data_transmitted === 1'b0 && tx_serial === 1'b1 && busy === 1'b0,
                              "after_done", data_transmitted, 0);
                    end
                end
            end
        end
    end

    // Stimulus and register-block model
    initial begin : stimulus
        int bad;
        bit found;
        reset       = 1'b1;
        tx_data     = 8'h00;
        load_signal = 1'b0;
        tx_signal   = 1'b0;
        baud_div    = 32'd4;
        stop_bit    = 2'b01;
        repeat (3) @(negedge clk);
        check(tx_serial === 1'b1, "reset_tx_serial", tx_serial, 1);
        check(busy === 1'b0, "reset_busy", busy, 0);
        check(data_transmitted === 1'b0, "reset_pulse", data_transmitted, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic 8N1, A5 -> 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit, pulse at 40
        tx_data = 8'hA5; baud_div = 32'd4; stop_bit = 2'b01;
        tx_signal = 1'b1; load_signal = 1'b1;
        push(mk(8'hA5, 4, 1, 1'b0, 0));
        wait_pulse("t1_pulse_seen");
        load_signal = 1'b0;
        repeat (5) @(negedge clk);

        // Two stop bits, 00 at 3 cycles per bit: 27 low, 6 high, pulse at 33
        tx_data = 8'h00; baud_div = 32'd3; stop_bit = 2'b10; load_signal = 1'b1;
        push(mk(8'h00, 3, 2, 1'b0, 0));
        wait_pulse("t2_pulse_seen");
        load_signal = 1'b0;
        repeat (5) @(negedge clk);

        // Transmit disabled with a byte waiting: line stays idle
        tx_signal = 1'b0; load_signal = 1'b1; bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || busy !== 1'b0 || data_transmitted !== 1'b0) bad++;
        end
        check(bad == 0, "no_enable_bad_cycles", bad, 0);
        load_signal = 1'b0; tx_signal = 1'b1;
        repeat (3) @(negedge clk);

        // Divisor 0 behaves as 1: one low cycle, nine high, pulse at 10
        tx_data = 8'hFF; baud_div = 32'd0; stop_bit = 2'b01; load_signal = 1'b1;
        push(mk(8'hFF, 1, 1, 1'b0, 0));
        wait_pulse("t5_pulse_seen");
        load_signal = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during data bit 3 (a zero bit of 33), then a full fresh frame
        tx_data = 8'h33; baud_div = 32'd4; stop_bit = 2'b01; load_signal = 1'b1;
        push(mk(8'h33, 4, 1, 1'b1, 0));
        push(mk(8'h33, 4, 1, 1'b0, 0));
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check(found, "t4_line_fall", found, 1);
        repeat (17) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check(tx_serial === 1'b1, "async_reset_tx_serial", tx_serial, 1);
        check(busy === 1'b0, "async_reset_busy", busy, 0);
        check(data_transmitted === 1'b0, "async_reset_pulse", data_transmitted, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_pulse("t4_pulse_seen");
        load_signal = 1'b0;
        repeat (5) @(negedge clk);

        // Back-to-back: refill 3C on the pulse, then disturb inputs mid-frame
        tx_data = 8'hC3; baud_div = 32'd4; stop_bit = 2'b01; load_signal = 1'b1;
        push(mk(8'hC3, 4, 1, 1'b0, 0));
        push(mk(8'h3C, 4, 1, 1'b0, 2));
        wait_pulse("t6a_pulse_seen");
        tx_data = 8'h3C;
        repeat (12) @(negedge clk);
        baud_div = 32'd7; stop_bit = 2'b10; tx_data = 8'hFF;
        wait_pulse("t6b_pulse_seen");
        load_signal = 1'b0;
        repeat (60) @(negedge clk);

        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        check(frames_seen == frames_pushed, "frame_count", frames_seen, frames_pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
